uart_receive: RTL

UART receiver that deserialises an asynchronous serial line into parallel words. It mirrors the transmit path: idle-high line, one start bit, DATA_WIDTH data bits LSB first, one stop bit, no parity. It sits directly downstream of the serial pin, or of uart_transmit in loopback. It delivers each received word with a one-cycle valid pulse to the command/packet layer.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_receive_counter.sv | 33 +++
 rtl/uart_receive.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and baud-period arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic int unsigned baud_period(input int unsigned freq, input int unsigned rate);
    return freq / rate;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/uart_receive_counter.sv
// Free-running modulo counter used for baud timing; counts 0..period_in-1 then wraps.
module uart_receive_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [Width:0]   period_in,
  output logic [Width-1:0] count_out
);

  logic [Width-1:0] count_q, count_d;
  logic [Width:0]   last;

  assign last = period_in - {{Width{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q + Width'(1);
    if ({1'b0, count_q} == last) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/uart_receive.sv
// UART receiver: 8N1-style framing, LSB first, one-cycle valid / framing-error pulses.
// Define UART_RX_SYNC_EN to insert a two-flop synchroniser on rx_wire_in.
module uart_receive
  import uart_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE        = 9600,
  parameter int unsigned DATA_WIDTH       = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_wire_in,
  output logic [DATA_WIDTH-1:0] data_byte_out,
  output logic                  new_data_out,
  output logic                  framing_err_out,
  output logic                  busy_out
);

  localparam int unsigned P    = baud_period(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned H    = P / 2;
  localparam int unsigned CntW = cnt_width(P);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW:0]   PeriodVal = (CntW + 1)'(P);
  localparam logic [CntW-1:0] HalfLast  = CntW'(H - 1);
  localparam logic [CntW-1:0] PerLast   = CntW'(P - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(DATA_WIDTH - 1);

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_wire_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx = rx_sync_q;
`else
  assign rx = rx_wire_in;
`endif

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  new_data_q, new_data_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  restart;
  logic [CntW-1:0]       count;
  logic [DATA_WIDTH:0]   shift_in;

  // Restart aligns count to the start edge so sample points fall on count compares.
  uart_receive_counter #(
    .Width (CntW)
  ) u_baud_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in | restart),
    .period_in (PeriodVal),
    .count_out (count)
  );

  assign shift_in = {rx, shreg_q};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    data_d     = data_q;
    new_data_d = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    restart    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx) begin
          state_d = StStart;
          restart = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (count == HalfLast) begin
          if (!rx) begin
            state_d = StData;
            restart = 1'b1;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (count == PerLast) begin
          shreg_d = shift_in[DATA_WIDTH:1];
          if (bit_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StStop: begin
        if (count == PerLast) begin
          if (rx) begin
            data_d     = shreg_q;
            new_data_d = 1'b1;
            state_d    = StIdle;
            busy_d     = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break must not be decoded as a stream of zero frames.
        if (rx) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      new_data_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      new_data_q <= new_data_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign data_byte_out   = data_q;
  assign new_data_out    = new_data_q;
  assign framing_err_out = err_q;
  assign busy_out        = busy_q;

endmodule
